// File: rtl/mul_share_arb.sv
// Shared-multiplier controller: arbitrates NREQ requesters onto one csam2c array multiplier.
// Define MULARB_FIXED_PRI_EN for fixed lowest-index-wins priority; otherwise round-robin.

// Functional model of the 16x16 two's-complement carry-save array: fifteen positive
// partial-product rows plus the negatively weighted sign row.
module csam2c (
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [31:0] p
);
  logic [31:0] xs;
  logic [31:0] acc;

  always_comb begin
    xs  = {{16{x[15]}}, x};
    acc = '0;
    for (int i = 0; i < 15; i++) begin
      if (y[i]) acc = acc + (xs << i);
    end
    if (y[15]) acc = acc - (xs << 15);
    p = acc;
  end
endmodule

module mul_share_arb #(
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*16-1:0] req_x,
  input  logic [NREQ*16-1:0] req_y,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [31:0]       rsp_p,
  output logic              busy,
  output logic [1:0]        dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // req_ready is offered only in IDLE, rsp_valid only in RESP, and RESP waits indefinitely.
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       op_x_q, op_x_d;
  logic [15:0]       op_y_q, op_y_d;
  logic [IW-1:0]     gnt_idx_q, gnt_idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       rsp_p_q, rsp_p_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [31:0]       mul_p;
  logic [IW-1:0]     start_idx;
  logic [IW-1:0]     gnt;
  logic              gnt_found;
  logic [IW:0]       scan_sum;
  logic [15:0]       x_arr [NREQ];
  logic [15:0]       y_arr [NREQ];

`ifdef MULARB_FIXED_PRI_EN
  assign start_idx = '0;
`else
  logic [IW-1:0] ptr_q, ptr_d;
  assign start_idx = ptr_q;
`endif

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign x_arr[i] = req_x[16*i+15:16*i];
    assign y_arr[i] = req_y[16*i+15:16*i];
  end

  // The array only ever sees the held operand registers, so its inputs are static in MUL.
  csam2c u_csam2c (
    .x (op_x_q),
    .y (op_y_q),
    .p (mul_p)
  );

  // First valid requester at or after start_idx, wrapping past NREQ-1.
  always_comb begin
    gnt_found = 1'b0;
    gnt       = '0;
    scan_sum  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, start_idx} + (IW+1)'(k);
      if (scan_sum >= (IW+1)'(NREQ)) scan_sum = scan_sum - (IW+1)'(NREQ);
      if (!gnt_found && req_valid[scan_sum[IW-1:0]]) begin
        gnt_found = 1'b1;
        gnt       = scan_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && gnt_found && !reset) req_ready[gnt] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    op_x_d      = op_x_q;
    op_y_d      = op_y_q;
    gnt_idx_d   = gnt_idx_q;
    cnt_d       = cnt_q;
    rsp_p_d     = rsp_p_q;
    rsp_valid_d = rsp_valid_q;
`ifndef MULARB_FIXED_PRI_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          op_x_d    = x_arr[gnt];
          op_y_d    = y_arr[gnt];
          gnt_idx_d = gnt;
          cnt_d     = 4'(LAT - 1);
          state_d   = ST_MUL;
        end
      end
      ST_MUL: begin
        if (cnt_q == 4'd0) begin
          rsp_p_d                = mul_p;
          rsp_valid_d            = '0;
          rsp_valid_d[gnt_idx_q] = 1'b1;
          state_d                = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready[gnt_idx_q]) begin
          rsp_valid_d = '0;
          state_d     = ST_IDLE;
`ifndef MULARB_FIXED_PRI_EN
          ptr_d = (gnt_idx_q == IW'(NREQ - 1)) ? '0 : gnt_idx_q + IW'(1);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_x_q      <= '0;
      op_y_q      <= '0;
      gnt_idx_q   <= '0;
      cnt_q       <= '0;
      rsp_p_q     <= '0;
      rsp_valid_q <= '0;
`ifndef MULARB_FIXED_PRI_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_x_q      <= op_x_d;
      op_y_q      <= op_y_d;
      gnt_idx_q   <= gnt_idx_d;
      cnt_q       <= cnt_d;
      rsp_p_q     <= rsp_p_d;
      rsp_valid_q <= rsp_valid_d;
`ifndef MULARB_FIXED_PRI_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb: directed steps with random operands checked
// against an arithmetic grant/product model and an expected-product queue.
module tb_mul_share_arb;
  localparam int NREQ  = 4;
  localparam int LAT   = 2;
  localparam int CLK_P = 10;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*16-1:0]  req_x;
  logic [NREQ*16-1:0]  req_y;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready;
  logic [31:0]         rsp_p;
  logic                busy;
  logic [1:0]          dbg_state;

  logic [15:0] opx [NREQ];
  logic [15:0] opy [NREQ];
  logic [31:0] exp_q [$];
  int          total_cnt = 0;
  int          pass_cnt  = 0;
  int          model_ptr = 0;

  // clock / reset block
  always #(CLK_P/2) clk = ~clk;

  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign req_x[16*i+15:16*i] = opx[i];
    assign req_y[16*i+15:16*i] = opy[i];
  end

  mul_share_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // reference model
  function automatic int model_grant(input logic [NREQ-1:0] vm);
    int start;
    logic [NREQ-1:0] sh;
`ifdef MULARB_FIXED_PRI_EN
    start = 0;
`else
    start = model_ptr;
`endif
    for (int k = 0; k < NREQ; k++) begin
      sh = vm >> ((start + k) % NREQ);
      if (sh[0]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_prod(input logic [15:0] x, input logic [15:0] y);
    longint px;
    px = longint'($signed(x)) * longint'($signed(y));
    return px[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // driver: called at a negedge with the DUT idle; returns at the negedge after completion
  task automatic serve(input logic [NREQ-1:0] vm, input int bp);
    int              g;
    logic [NREQ-1:0] oh;
    logic [31:0]     e;
    g  = model_grant(vm);
    oh = NREQ'(1) << g;
    req_valid = vm;
    rsp_ready = (bp > 0) ? ~oh : '1;
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("grant", 32'(req_ready), 32'(oh));
    exp_q.push_back(model_prod(opx[g], opy[g]));
    @(negedge clk);
    opx[g] = 16'($urandom);
    opy[g] = 16'($urandom);
    for (int k = 0; k < LAT; k++) begin
      chk("mul_busy", 32'(busy), 32'd1);
      chk("mul_no_ready", 32'(req_ready), 32'd0);
      chk("mul_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    e = exp_q.pop_front();
    chk("rsp_valid", 32'(rsp_valid), 32'(oh));
    chk("rsp_p", rsp_p, e);
    chk("resp_no_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'(oh));
      chk("bp_rsp_p", rsp_p, e);
      chk("bp_no_ready", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
    end
    rsp_ready = '1;
    @(negedge clk);
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    model_ptr = (g + 1) % NREQ;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] tx [3];
    logic [15:0] ty [3];
    logic [31:0] tp [3];
    tx[0] = 16'h8000; ty[0] = 16'h8000; tp[0] = 32'h4000_0000;
    tx[1] = 16'h7FFF; ty[1] = 16'h8000; tp[1] = 32'hC000_8000;
    tx[2] = 16'h0000; ty[2] = 16'hFFFF; tp[2] = 32'h0000_0000;

    reset = 1'b1; req_valid = '0; rsp_ready = '0;
    for (int i = 0; i < NREQ; i++) begin opx[i] = '0; opy[i] = '0; end

    // reset state, with every requester asking
    @(negedge clk);
    req_valid = '1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_p", rsp_p, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b0; req_valid = '0;
    #1;
    chk("idle_no_req", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("idle_stays", 32'(busy), 32'd0);

    // single op
    opx[0] = 16'd3; opy[0] = 16'hFFFB;
    serve(4'b0001, 0);
    chk("single_p", rsp_p, 32'hFFFF_FFF1);

    // extremes
    for (int i = 0; i < 3; i++) begin
      opx[i] = tx[i]; opy[i] = ty[i];
      serve(NREQ'(1) << i, 0);
      chk("extreme_p", rsp_p, tp[i]);
    end

    // random masks, operands and backpressure
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NREQ; i++) begin opx[i] = 16'($urandom); opy[i] = 16'($urandom); end
      serve(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(0, 3));
    end

    // round-robin from a freshly reset pointer
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; model_ptr = 0;
    for (int n = 0; n < 5; n++) serve('1, 0);

    // five cycles of backpressure on requester 1
    serve(4'b0010, 5);

    // reset one cycle after the handshake
    req_valid = 4'b0010; rsp_ready = '1;
    #1;
    chk("rst_mul_grant", 32'(req_ready), 32'b0010);
    @(negedge clk);
    chk("rst_mul_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mul_ready", 32'(req_ready), 32'd0);
    chk("rst_mul_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mul_rsp_p", rsp_p, 32'd0);
    chk("rst_mul_busy0", 32'(busy), 32'd0);
    @(negedge clk);
    chk("rst_hold_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0; req_valid = '0; model_ptr = 0;
    @(negedge clk);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    serve(4'b0101, 0);
    serve(4'b0100, 0);

    // requesters 0 and 3 both held valid
    for (int n = 0; n < 3; n++) serve(4'b1001, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
